// File: rtl/bank_addr_pkg.sv
// Shared types, constants and helpers for the coefficient-bank address generator.
package bank_addr_pkg;

    localparam int unsigned N          = 256;
    localparam int unsigned BANK_DEPTH = 128;
    localparam int unsigned P_MAX      = 4;
    localparam int unsigned TW_BASE_P0 = 128;

    localparam int unsigned COEF_W = 8;
    localparam int unsigned BANK_W = 7;
    localparam int unsigned TW_W   = 8;

    typedef logic [COEF_W-1:0] coef_idx_t;
    typedef logic [BANK_W-1:0] bank_addr_t;
    typedef logic [TW_W-1:0]   tw_addr_t;

    // One bank access: both word addresses plus the lane-crossing control.
    typedef struct packed {
        logic       valid;
        bank_addr_t addr0;
        bank_addr_t addr1;
        logic       swap;
    } bank_req_t;

    // Bank of a coefficient index: XOR-reduction of all its bits.
    function automatic logic parity(input coef_idx_t x);
        return ^x;
    endfunction

endpackage

// File: rtl/addr_delay_line.sv
// Fixed-depth register chain carrying bank requests from read issue to write-back.
module addr_delay_line
    import bank_addr_pkg::*;
#(
    parameter int unsigned DEPTH = 14,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps [DEPTH];

    // Shifts every cycle; bubbles travel through as zero-valid entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                taps[i] <= '0;
            end
        end else begin
            taps[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/bank_addr_gen.sv
// Maps NTT/PWM/INTT loop indices (k, j, p) to conflict-free two-bank addresses and a twiddle address.
// Optional sticky index/bank checker enabled by defining BANK_CONFLICT_CHECK_EN.
module bank_addr_gen
    import bank_addr_pkg::*;
#(
    parameter int unsigned WR_LAT = 14,
    parameter int unsigned N_LOG  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    input  logic [6:0] k,
    input  logic [6:0] j,
    input  logic [2:0] p,
    output logic       rd_valid,
    output logic [6:0] rd_addr0,
    output logic [6:0] rd_addr1,
    output logic       rd_swap,
    output logic [7:0] tw_addr,
    output logic       wr_valid,
    output logic [6:0] wr_addr0,
    output logic [6:0] wr_addr1,
    output logic       wr_swap,
    output logic       err
);

    localparam int unsigned N_POLY  = 1 << N_LOG;
    localparam logic [2:0]  P_MAX_3 = 3'(P_MAX);

    logic [2:0] p_eff_c;
    logic [3:0] sh_c;
    coef_idx_t  half_c;
    coef_idx_t  a_c;
    bank_addr_t a_word_c;
    bank_addr_t b_word_c;
    logic       swap_c;
    tw_addr_t   tw_c;
    bank_req_t  rd_req;
    bank_req_t  wr_req;

    // Element pair and twiddle index for the current loop indices.
    always_comb begin
        p_eff_c  = (p > P_MAX_3) ? 3'd0 : p;
        sh_c     = {p_eff_c, 1'b0};
        half_c   = COEF_W'((9'd1 << sh_c) >> 1);
        a_c      = '0;
        b_word_c = '0;
        tw_c     = '0;
        if (p_eff_c == 3'd0) begin
            a_c      = {k, 1'b0};
            b_word_c = k;
            tw_c     = TW_W'(TW_BASE_P0) + TW_W'(k);
        end else begin
            a_c      = COEF_W'(16'(k) << sh_c) + COEF_W'(j);
            b_word_c = BANK_W'((a_c + half_c) >> 1);
            tw_c     = TW_W'(N_POLY >> sh_c) + TW_W'(k);
        end
        a_word_c = a_c[7:1];
        swap_c   = parity(a_c);
    end

    // Read-side registers; addresses hold across idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_addr0 <= '0;
            rd_addr1 <= '0;
            rd_swap  <= 1'b0;
            tw_addr  <= '0;
        end else begin
            rd_valid <= valid_in;
            if (valid_in) begin
                rd_addr0 <= swap_c ? b_word_c : a_word_c;
                rd_addr1 <= swap_c ? a_word_c : b_word_c;
                rd_swap  <= swap_c;
                tw_addr  <= tw_c;
            end
        end
    end

    always_comb begin
        rd_req       = '0;
        rd_req.valid = rd_valid;
        rd_req.addr0 = rd_addr0;
        rd_req.addr1 = rd_addr1;
        rd_req.swap  = rd_swap;
    end

    addr_delay_line #(
        .DEPTH (WR_LAT),
        .WIDTH ($bits(bank_req_t))
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (rd_req),
        .dout (wr_req)
    );

    assign wr_valid = wr_req.valid;
    assign wr_addr0 = wr_req.addr0;
    assign wr_addr1 = wr_req.addr1;
    assign wr_swap  = wr_req.swap;

`ifdef BANK_CONFLICT_CHECK_EN
    coef_idx_t   b_full_c;
    logic [15:0] k_span_c;
    logic        viol_c;

    // Independent recomputation of b so a broken pairing shows up as same-bank access.
    always_comb begin
        b_full_c = (p_eff_c == 3'd0) ? {k, 1'b1} : (a_c + half_c);
        k_span_c = 16'(k) << sh_c;
        viol_c   = (p > P_MAX_3) || (parity(a_c) == parity(b_full_c));
        if (p_eff_c != 3'd0) begin
            viol_c = viol_c || (COEF_W'(j) >= half_c) || (k_span_c >= 16'(N));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (valid_in && viol_c) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bank_addr_gen.sv
// Self-checking bench for bank_addr_gen: arithmetic reference model plus directed literal checks.
module tb_bank_addr_gen;

    localparam int WR_LAT = 14;
`ifdef BANK_CONFLICT_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid_in = 1'b0;
    logic [6:0] k = '0;
    logic [6:0] j = '0;
    logic [2:0] p = '0;
    logic       rd_valid, rd_swap, wr_valid, wr_swap, err;
    logic [6:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
    logic [7:0] tw_addr;

    always #5 clk = ~clk;

    bank_addr_gen #(.WR_LAT(WR_LAT), .N_LOG(8)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .k(k), .j(j), .p(p),
        .rd_valid(rd_valid), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_swap(rd_swap),
        .tw_addr(tw_addr), .wr_valid(wr_valid), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
        .wr_swap(wr_swap), .err(err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: element pair from the stage rules, then bank = popcount parity.
    task automatic model_addr(input int kk, input int jj, input int pp,
                              output int a0, output int a1, output int sw,
                              output int tw, output int pe_o, output bit bad);
        int pe, a, b, jw, hw;
        pe = (pp > 4) ? 0 : pp;
        jw = 1;
        hw = 0;
        if (pe == 0) begin
            a  = 2 * kk;
            b  = a + 1;
            tw = 128 + kk;
        end else begin
            jw = 1 << (2 * pe);
            hw = jw / 2;
            a  = (kk * jw + jj) % 256;
            b  = (a + hw) % 256;
            tw = ((256 >> (2 * pe)) + kk) % 256;
        end
        sw   = $countones(a) % 2;
        bad  = (pp > 4) || (sw == ($countones(b) % 2)) || (pe > 0 && (jj >= hw || kk >= 256 / jw));
        a0   = sw ? b / 2 : a / 2;
        a1   = sw ? a / 2 : b / 2;
        pe_o = pe;
    endtask

    int m_rd_v = 0, m_a0 = 0, m_a1 = 0, m_sw = 0, m_tw = 0, m_rd_p = 0, m_err = 0;
    int m_wr_v = 0, m_wa0 = 0, m_wa1 = 0, m_wsw = 0;
    int h_v [WR_LAT], h_a0 [WR_LAT], h_a1 [WR_LAT], h_sw [WR_LAT];
    int t_a0, t_a1, t_sw, t_tw, t_pe;
    bit t_bad;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rd_v = 0; m_a0 = 0; m_a1 = 0; m_sw = 0; m_tw = 0; m_err = 0;
            m_wr_v = 0; m_wa0 = 0; m_wa1 = 0; m_wsw = 0;
            for (int i = 0; i < WR_LAT; i++) begin
                h_v[i] = 0; h_a0[i] = 0; h_a1[i] = 0; h_sw[i] = 0;
            end
        end else begin
            for (int i = WR_LAT - 1; i > 0; i--) begin
                h_v[i] = h_v[i-1]; h_a0[i] = h_a0[i-1]; h_a1[i] = h_a1[i-1]; h_sw[i] = h_sw[i-1];
            end
            h_v[0] = m_rd_v; h_a0[0] = m_a0; h_a1[0] = m_a1; h_sw[0] = m_sw;
            m_wr_v = h_v[WR_LAT-1]; m_wa0 = h_a0[WR_LAT-1];
            m_wa1 = h_a1[WR_LAT-1]; m_wsw = h_sw[WR_LAT-1];
            m_rd_v = int'(valid_in);
            if (valid_in) begin
                model_addr(int'(k), int'(j), int'(p), t_a0, t_a1, t_sw, t_tw, t_pe, t_bad);
                m_a0 = t_a0; m_a1 = t_a1; m_sw = t_sw; m_tw = t_tw; m_rd_p = t_pe;
                if (t_bad && CHK_EN) m_err = 1;
            end
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rd_valid", rd_valid, m_rd_v);
            chk("rd_addr0", rd_addr0, m_a0);
            chk("rd_addr1", rd_addr1, m_a1);
            chk("rd_swap",  rd_swap,  m_sw);
            chk("tw_addr",  tw_addr,  m_tw);
            chk("wr_valid", wr_valid, m_wr_v);
            chk("wr_addr0", wr_addr0, m_wa0);
            chk("wr_addr1", wr_addr1, m_wa1);
            chk("wr_swap",  wr_swap,  m_wsw);
            chk("err",      err,      m_err);
        end
    end

    // Per-stage bank word coverage during the sweep.
    bit sweep_on = 1'b0;
    int cnt0 [5][128];
    int cnt1 [5][128];

    always @(negedge clk) begin
        if (sweep_on && rd_valid === 1'b1 && m_rd_p >= 0 && m_rd_p <= 4) begin
            cnt0[m_rd_p][rd_addr0]++;
            cnt1[m_rd_p][rd_addr1]++;
        end
    end

    task automatic step(input bit v, input int kk, input int jj, input int pp);
        @(negedge clk);
        valid_in = v;
        k = 7'(kk);
        j = 7'(jj);
        p = 3'(pp);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        bit ok;
        int nk, nj;

        #1 rst = 1'b1;
        #1 cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_wr_valid", wr_valid, 0);
        chk("reset_tw_addr",  tw_addr,  0);
        chk("reset_err",      err,      0);
        rst = 1'b0;

        step(1, 0, 0, 4);
        step(0, 0, 0, 0);
        chk("p4_rd_valid", rd_valid, 1);
        chk("p4_rd_addr0", rd_addr0, 0);
        chk("p4_rd_addr1", rd_addr1, 64);
        chk("p4_rd_swap",  rd_swap,  0);
        chk("p4_tw_addr",  tw_addr,  1);

        step(1, 5, 1, 1);
        step(0, 0, 0, 0);
        chk("p1_rd_swap",  rd_swap,  1);
        chk("p1_rd_addr0", rd_addr0, 11);
        chk("p1_rd_addr1", rd_addr1, 10);
        chk("p1_tw_addr",  tw_addr,  69);

        step(1, 127, 0, 0);
        step(0, 0, 0, 0);
        chk("p0_rd_swap",  rd_swap,  1);
        chk("p0_rd_addr0", rd_addr0, 127);
        chk("p0_rd_addr1", rd_addr1, 127);
        chk("p0_tw_addr",  tw_addr,  255);

        step(0, 0, 0, 0);
        chk("idle_rd_valid", rd_valid, 0);
        chk("idle_hold_addr0", rd_addr0, 127);
        chk("idle_hold_tw", tw_addr, 255);

        // Stages 4..0 back-to-back, FSM loop order.
        sweep_on = 1'b1;
        for (int s = 4; s >= 0; s--) begin
            if (s == 0) begin
                nk = 128; nj = 1;
            end else begin
                nk = 256 >> (2 * s); nj = (1 << (2 * s)) / 2;
            end
            for (int kk = 0; kk < nk; kk++) begin
                for (int jj = 0; jj < nj; jj++) begin
                    step(1, kk, jj, s);
                end
            end
        end
        step(0, 0, 0, 0);
        repeat (WR_LAT + 2) @(negedge clk);
        sweep_on = 1'b0;
        for (int s = 0; s < 5; s++) begin
            ok = 1'b1;
            for (int w = 0; w < 128; w++) begin
                if (cnt0[s][w] != 1 || cnt1[s][w] != 1) ok = 1'b0;
            end
            chk($sformatf("sweep_cover_p%0d", s), 32'(ok), 1);
        end

        // Illegal stage behaves as stage 0; bad indices flag err when the checker is built.
        step(1, 3, 0, 6);
        step(0, 0, 0, 0);
        chk("p6_rd_addr0", rd_addr0, 3);
        chk("p6_rd_addr1", rd_addr1, 3);
        chk("p6_rd_swap",  rd_swap,  0);
        chk("p6_tw_addr",  tw_addr,  131);
        chk("p6_err", err, CHK_EN ? 1 : 0);
        step(1, 0, 8, 2);
        repeat (4) step(0, 0, 0, 0);
        chk("err_sticky", err, CHK_EN ? 1 : 0);

        // Reset with several entries in flight.
        step(1, 1, 0, 1);
        step(0, 0, 0, 0);
        step(1, 2, 0, 1);
        step(1, 3, 0, 1);
        step(1, 4, 0, 1);
        step(1, 5, 0, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_addr0", rd_addr0, 0);
        chk("rst_rd_addr1", rd_addr1, 0);
        chk("rst_tw_addr",  tw_addr,  0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_err",      err,      0);
        valid_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        step(1, 7, 1, 1);
        c = 0;
        while (c < 40) begin
            @(posedge clk);
            c++;
            #1;
            if (c == 1) valid_in = 1'b0;
            if (wr_valid === 1'b1) break;
        end
        chk("wr_latency_after_rst", c, 15);
        chk("wr_addr0_after_rst", wr_addr0, 14);
        chk("wr_addr1_after_rst", wr_addr1, 15);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
